shift_reg_piso_tx: RTL and testbench



---
 rtl/shift_reg_piso_tx.sv | 142 ++++++++++++++
 tb/tb_shift_reg_piso_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_piso_tx
// Description : Parallel-in/serial-out transmit serializer. It buffers one
//               word and shifts it out one bit per clock, optionally followed
//               by an even-parity bit, and marks the last bit of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int             c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST_BIT = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_PAR   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [c_CW-1:0]  r_cnt;
    logic             r_parity;

    logic             w_accept;
    logic             w_load;
    logic             w_frame_end;
    logic             w_last_data;
    logic             w_shift_out;
    logic [WIDTH-1:0] w_shift_next;

    // Shift direction decides which end of the shifter drives the line.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_out  = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shift_out  = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign din_ready   = !r_hold_full && !reset;
    assign w_accept    = din_valid && din_ready;
    assign w_last_data = (r_state == c_S_SHIFT) && (r_cnt == c_LAST_BIT);

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
                    if (PARITY_EN) begin
                        w_state_next = c_S_PAR;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            c_S_PAR: begin
                w_frame_end = 1'b1;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
        // A held word at frame end reloads straight into SHIFT, so frames abut.
        if (w_frame_end) begin
            if (r_hold_full) begin
                w_load       = 1'b1;
                w_state_next = c_S_SHIFT;
            end else begin
                w_state_next = c_S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
        end else begin
            // Accept and load are mutually exclusive: accept needs an empty hold.
            if (w_accept) begin
                r_hold      <= din;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift  <= r_hold;
                r_parity <= ^r_hold;
                r_cnt    <= '0;
            end else if (r_state == c_S_SHIFT) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign sout_valid = (r_state == c_S_SHIFT) || (r_state == c_S_PAR);
    assign sout_last  = (w_last_data && !PARITY_EN) || (r_state == c_S_PAR);
    assign sout       = (r_state == c_S_SHIFT) ? w_shift_out :
                        (r_state == c_S_PAR)   ? r_parity    : 1'b0;
    assign busy       = (r_state != c_S_IDLE) || r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_piso_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shift_reg_piso_tx
// Description : Self-checking bench for shift_reg_piso_tx in two parameter
//               configurations, checked against a frame-level bit-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din0, din1;
    logic       dv0, dv1;
    logic       rdy0, rdy1, so0, so1, sv0, sv1, sl0, sl1, bz0, bz1;

    always #5 clk = ~clk;

    shift_reg_piso_tx #(.WIDTH(4), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .sout_last(sl0), .busy(bz0)
    );

    shift_reg_piso_tx #(.WIDTH(4), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .sout_last(sl1), .busy(bz1)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] tx_q[$];
    logic [1:0] exp_q[$];   // {last, bit}
    logic [1:0] obs_q[$];

    // Expected serial frame of one word, built from the bit ordering and parity rules.
    function automatic void push_frame(input logic [3:0] w, input bit pe, input bit msb);
        for (int i = 0; i < 4; i++) begin
            logic b;
            b = msb ? w[3-i] : w[i];
            exp_q.push_back({(!pe && i == 3), b});
        end
        if (pe) begin
            logic p;
            p = ($countones(w) % 2) != 0;
            exp_q.push_back({1'b1, p});
        end
    endfunction

    // {din_ready, sout, sout_valid, sout_last, busy}
    function automatic logic [4:0] outs(input int sel);
        return (sel == 0) ? {rdy0, so0, sv0, sl0, bz0} : {rdy1, so1, sv1, sl1, bz1};
    endfunction

    task automatic set_in(input int sel, input logic [3:0] d, input logic v);
        if (sel == 0) begin
            din0 = d; dv0 = v;
        end else begin
            din1 = d; dv1 = v;
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({so0, sv0, sl0, bz0, rdy0, so1, sv1, sl1, bz1, rdy1} !== 10'b0) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected 0000000000", name,
                     {so0, sv0, sl0, bz0, rdy0, so1, sv1, sl1, bz1, rdy1});
        end
    endtask

    // Feeds tx_q into a DUT and checks the collected stream against the model.
    task automatic run_words(input int sel, input string name, input bit pe, input bit msb,
                             input int gap_pct, input bit chk_contig, input int max_cycles);
        int         first_acc, first_valid, last_valid, hs, nlast, cycles;
        bit         done, presented;
        logic [4:0] o;
        exp_q.delete();
        obs_q.delete();
        first_acc = -1; first_valid = -1; last_valid = -1;
        hs = 0; nlast = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < max_cycles) begin
            @(posedge clk);
            cycles++;
            #1;
            o = outs(sel);
            if (o[2]) begin
                obs_q.push_back({o[1], o[3]});
                if (first_valid < 0) first_valid = cycles;
                last_valid = cycles;
                if (o[1]) nlast++;
            end else begin
                n_checks++;
                if (o[3] !== 1'b0 || o[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_outputs: sout/last got %b%b expected 00", name, o[3], o[1]);
                end
            end
            presented = 1'b0;
            if (tx_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                set_in(sel, tx_q[0], 1'b1);
                presented = 1'b1;
                if (o[4]) begin
                    push_frame(tx_q.pop_front(), pe, msb);
                    hs++;
                    if (first_acc < 0) first_acc = cycles + 1;
                end
            end else begin
                set_in(sel, 4'($urandom), 1'b0);
            end
            done = !presented && (tx_q.size() == 0) && !o[0];
        end
        set_in(sel, 4'h0, 1'b0);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: done got 0 expected 1 after %0d cycles", name, max_cycles);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s stream_len: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s bit[%0d] {last,sout}: got %b expected %b", name, i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (nlast !== hs) begin
            n_fail++;
            $display("FAIL %s frames_vs_handshakes: got %0d frames expected %0d", name, nlast, hs);
        end
        n_checks++;
        if (first_valid !== first_acc + 1) begin
            n_fail++;
            $display("FAIL %s latency: first bit cycle got %0d expected %0d", name, first_valid, first_acc + 1);
        end
        if (chk_contig) begin
            n_checks++;
            if (last_valid - first_valid + 1 !== obs_q.size()) begin
                n_fail++;
                $display("FAIL %s contiguous: span got %0d expected %0d", name,
                         last_valid - first_valid + 1, obs_q.size());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 4'h0, 1'b0);
        set_in(1, 4'h0, 1'b0);
        #2;
        check_all_zero("reset_initial");
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release din_ready: got %b expected 11", {rdy0, rdy1});
        end
        // Start a frame on the parity DUT, then reset mid-cycle while it shifts.
        @(posedge clk); #1;
        set_in(0, 4'hC, 1'b1);
        @(posedge clk); #1;
        set_in(0, 4'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (sv0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_frame_active sout_valid: got %b expected 1", sv0);
        end
        #2 reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_after din_ready: got %b expected 1", rdy0);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({sv0, bz0, sv1, bz1} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_quiet valid/busy: got %b expected 0000", {sv0, bz0, sv1, bz1});
            end
        end
    endtask

    task automatic test_single();
        tx_q.delete();
        tx_q.push_back(4'b1011);
        run_words(0, "single_1011", 1'b1, 1'b1, 0, 1'b1, 40);
    endtask

    task automatic test_back_to_back();
        tx_q.delete();
        tx_q.push_back(4'hA);
        tx_q.push_back(4'h5);
        run_words(0, "back_to_back", 1'b1, 1'b1, 0, 1'b1, 60);
    endtask

    task automatic test_backpressure();
        tx_q.delete();
        tx_q.push_back(4'hA);
        tx_q.push_back(4'h5);
        tx_q.push_back(4'hF);
        run_words(0, "backpressure", 1'b1, 1'b1, 0, 1'b1, 80);
    endtask

    task automatic test_reset_mid_shift();
        @(posedge clk); #1;
        set_in(0, 4'hC, 1'b1);
        @(posedge clk); #1;                 // C accepted
        set_in(0, 4'h9, 1'b1);
        @(posedge clk); #1;                 // C loaded, first bit
        @(posedge clk); #1;                 // 9 accepted into hold
        set_in(0, 4'h0, 1'b0);
        @(posedge clk); #1;                 // third data bit of C
        n_checks++;
        if ({sv0, so0, bz0} !== 3'b101) begin
            n_fail++;
            $display("FAIL midshift_third_bit {valid,sout,busy}: got %b expected 101", {sv0, so0, bz0});
        end
        #2 reset = 1'b1;
        #1;
        check_all_zero("midshift_reset");
        @(negedge clk);
        reset = 1'b0;
        tx_q.delete();
        tx_q.push_back(4'h3);
        run_words(0, "after_reset_3", 1'b1, 1'b1, 0, 1'b1, 40);
    endtask

    task automatic test_lsb_no_parity();
        tx_q.delete();
        tx_q.push_back(4'b0001);
        run_words(1, "lsb_noparity_0001", 1'b0, 1'b0, 0, 1'b1, 40);
    endtask

    task automatic test_random();
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(4'($urandom));
        run_words(0, "random_gaps_par", 1'b1, 1'b1, 40, 1'b0, 2000);
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(4'($urandom));
        run_words(1, "random_gaps_lsb", 1'b0, 1'b0, 40, 1'b0, 2000);
        tx_q.delete();
        for (int i = 0; i < 12; i++) tx_q.push_back(4'($urandom));
        run_words(1, "random_stream_lsb", 1'b0, 1'b0, 0, 1'b1, 1000);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_lsb_no_parity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time got 200000 expected less");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
